// File: rtl/mux41_scan_pkg.sv
// Shared types and constants for the 4:1 mux channel scanner.
package mux41_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_VALID = 2'd2
  } scan_state_e;

  localparam int DEF_NCH   = 4;
  localparam int DEF_SELW  = 2;
  localparam int DWELL_MAX = 15;

  // Wide enough to hold DWELL_MAX-1, the largest terminal count.
  localparam int CNT_W = $clog2(DWELL_MAX + 1);

endpackage

// File: rtl/scan_dwell_cnt.sv
// Dwell timer for the scanner: counts up from 0 while enabled and flags
// the terminal count at DWELL-1, wrapping back to 0 on that edge.
module scan_dwell_cnt
  import mux41_scan_pkg::*;
#(
  parameter int DWELL = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tc_o = en_i && (cnt_q == TC_VAL);

  // Next count: clear wins, otherwise advance and wrap at terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (tc_o) cnt_d = '0;
      else      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mux41_scan_ctrl.sv
// Channel scanner for the 4:1 mux: steps the select through every channel,
// samples y once per channel after a dwell time, and offers the assembled
// snapshot on a valid/ready handshake.
// Optional build macro MUX41_SCAN_CHANGE_DETECT_EN adds a `changed` output
// flagging that the new snapshot differs from the previous one.
//
// state    | meaning
// ---------+----------------------------------------------------
// ST_IDLE  | waiting for start, s parked at 0
// ST_SCAN  | walking s through channels, sampling y at dwell end
// ST_VALID | snapshot presented, waiting for snap_ready
module mux41_scan_ctrl
  import mux41_scan_pkg::*;
#(
  parameter int NCH   = DEF_NCH,
  parameter int SELW  = DEF_SELW,
  parameter int DWELL = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [SELW-1:0] s,
  input  logic            y,
  output logic [NCH-1:0]  snap,
  output logic            snap_valid,
  input  logic            snap_ready,
  output logic            busy
`ifdef MUX41_SCAN_CHANGE_DETECT_EN
  ,
  output logic            changed
`endif
);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] SCAN  = ST_SCAN;
  localparam logic [1:0] VALID = ST_VALID;

  localparam logic [SELW-1:0] S_LAST = SELW'(NCH - 1);

  logic [1:0]      state_q,  state_d;
  logic [SELW-1:0] s_q,      s_d;
  logic [NCH-1:0]  shadow_q, shadow_d;
  logic [NCH-1:0]  snap_q,   snap_d;
  logic            valid_q,  valid_d;
  logic            busy_q,   busy_d;
  logic [NCH-1:0]  snap_new;
  logic            snap_load;
  logic            dwell_tc;

  scan_dwell_cnt #(.DWELL(DWELL)) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (state_q != SCAN),
    .en_i  (state_q == SCAN),
    .tc_o  (dwell_tc)
  );

  // Final channel is taken straight from y since its shadow bit is not yet written.
  always_comb begin
    snap_new          = shadow_q;
    snap_new[NCH-1]   = y;
  end

  assign snap_load = (state_q == SCAN) && dwell_tc && (s_q == S_LAST);

  // Next-state logic for the scan FSM and snapshot registers.
  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    shadow_d = shadow_q;
    snap_d   = snap_q;
    valid_d  = valid_q;
    case (state_q)
      IDLE: begin
        s_d = '0;
        if (start) state_d = SCAN;
      end
      SCAN: begin
        if (dwell_tc) begin
          shadow_d[s_q] = y;
          if (s_q == S_LAST) begin
            snap_d  = snap_new;
            valid_d = 1'b1;
            s_d     = '0;
            state_d = VALID;
          end else begin
            s_d = s_q + SELW'(1);
          end
        end
      end
      VALID: begin
        if (snap_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        s_d     = '0;
        valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset overrides any scan or handshake in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      s_q      <= '0;
      shadow_q <= '0;
      snap_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      shadow_q <= shadow_d;
      snap_q   <= snap_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

`ifdef MUX41_SCAN_CHANGE_DETECT_EN
  logic [NCH-1:0] prev_snap_q;
  logic           changed_q;

  // Compare each freshly loaded snapshot against the one before it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_snap_q <= '0;
      changed_q   <= 1'b0;
    end else if (snap_load) begin
      changed_q   <= (snap_new != prev_snap_q);
      prev_snap_q <= snap_new;
    end
  end

  assign changed = changed_q;
`endif

  assign s          = s_q;
  assign snap       = snap_q;
  assign snap_valid = valid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_mux41_scan_ctrl.sv
// Directed bench for mux41_scan_ctrl: one instance with DWELL=1 and one with
// DWELL=2, each fed by a behavioural 4:1 mux model (y = i[s]).
module tb_mux41_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       st1, rdy1, st2, rdy2;
  logic [3:0] iv1, iv2;
  logic [1:0] s1, s2;
  logic [3:0] snap1, snap2;
  logic       v1, v2, busy1, busy2;
  logic       y1, y2;
`ifdef MUX41_SCAN_CHANGE_DETECT_EN
  logic       ch1, ch2;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign y1 = iv1[s1];
  assign y2 = iv2[s2];

  mux41_scan_ctrl #(.NCH(4), .SELW(2), .DWELL(1)) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (st1),
    .s          (s1),
    .y          (y1),
    .snap       (snap1),
    .snap_valid (v1),
    .snap_ready (rdy1),
    .busy       (busy1)
`ifdef MUX41_SCAN_CHANGE_DETECT_EN
    ,
    .changed    (ch1)
`endif
  );

  mux41_scan_ctrl #(.NCH(4), .SELW(2), .DWELL(2)) dut2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (st2),
    .s          (s2),
    .y          (y2),
    .snap       (snap2),
    .snap_valid (v2),
    .snap_ready (rdy2),
    .busy       (busy2)
`ifdef MUX41_SCAN_CHANGE_DETECT_EN
    ,
    .changed    (ch2)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start a DWELL=1 scan of pattern iv and run the 4 edges to valid.
  task automatic scan1(input logic [3:0] iv);
    iv1 = iv;
    st1 = 1'b1;
    tick();
    st1 = 1'b0;
    repeat (4) tick();
  endtask

  task automatic accept1();
    rdy1 = 1'b1;
    tick();
    rdy1 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    st1 = 1'b0; rdy1 = 1'b0; iv1 = 4'b0000;
    st2 = 1'b0; rdy2 = 1'b0; iv2 = 4'b0000;
    repeat (2) tick();
    rst_n = 1'b1;

    chk("rst_s",     32'(s1),    32'h0);
    chk("rst_snap",  32'(snap1), 32'h0);
    chk("rst_valid", 32'(v1),    32'h0);
    chk("rst_busy",  32'(busy1), 32'h0);
`ifdef MUX41_SCAN_CHANGE_DETECT_EN
    chk("rst_changed", 32'(ch1), 32'h0);
`endif

    // Basic scan of 0101 with observed select sequence.
    iv1 = 4'b0101;
    st1 = 1'b1;
    tick();
    st1 = 1'b0;
    chk("t1_s0",    32'(s1),    32'h0);
    chk("t1_busy",  32'(busy1), 32'h1);
    tick(); chk("t1_s1", 32'(s1), 32'h1);
    tick(); chk("t1_s2", 32'(s1), 32'h2);
    tick(); chk("t1_s3", 32'(s1), 32'h3);
    chk("t1_not_valid_early", 32'(v1), 32'h0);
    tick();
    chk("t1_valid", 32'(v1),    32'h1);
    chk("t1_snap",  32'(snap1), 32'h5);
    chk("t1_s_back", 32'(s1),   32'h0);
    chk("t1_busy_valid", 32'(busy1), 32'h1);
    accept1();
    chk("t1_acc_valid", 32'(v1),    32'h0);
    chk("t1_acc_busy",  32'(busy1), 32'h0);
    chk("t1_snap_kept", 32'(snap1), 32'h5);

    // Back-pressure: hold ready low, pulse start, snapshot must not move.
    scan1(4'b1000);
    chk("t2_snap", 32'(snap1), 32'h8);
    for (int k = 0; k < 10; k++) begin
      st1 = k[0];
      iv1 = 4'(k);
      tick();
      chk("t2_hold", {27'd0, v1, snap1}, {27'd0, 1'b1, 4'b1000});
    end
    st1 = 1'b1;
    rdy1 = 1'b1;
    tick();
    st1 = 1'b0;
    rdy1 = 1'b0;
    chk("t2_acc_valid", 32'(v1),    32'h0);
    chk("t2_acc_busy",  32'(busy1), 32'h0);
    tick();
    chk("t2_start_ignored", 32'(busy1), 32'h0);
    rdy1 = 1'b1;
    tick();
    rdy1 = 1'b0;
    chk("t2_stray_ready", {30'd0, busy1, v1}, 32'h0);

    // DWELL=2 with an input change during channel 2's non-sampling cycle.
    iv2 = 4'b0110;
    st2 = 1'b1;
    tick();
    st2 = 1'b0;
    chk("t3_e0", 32'(s2), 32'h0);
    tick(); chk("t3_e1", 32'(s2), 32'h0);
    tick(); chk("t3_e2", 32'(s2), 32'h1);
    tick(); chk("t3_e3", 32'(s2), 32'h1);
    tick(); chk("t3_e4", 32'(s2), 32'h2);
    iv2 = 4'b1111;
    tick(); chk("t3_e5", 32'(s2), 32'h2);
    tick(); chk("t3_e6", 32'(s2), 32'h3);
    tick(); chk("t3_e7", 32'(s2), 32'h3);
    chk("t3_not_valid_e7", 32'(v2), 32'h0);
    tick();
    chk("t3_valid", 32'(v2),    32'h1);
    chk("t3_snap",  32'(snap2), 32'hE);
    rdy2 = 1'b1;
    tick();
    rdy2 = 1'b0;
    chk("t3_acc", 32'(v2), 32'h0);

    // Reset mid-scan, then a clean scan.
    iv1 = 4'b1111;
    st1 = 1'b1;
    tick();
    st1 = 1'b0;
    tick();
    tick();
    chk("t4_mid_s", 32'(s1), 32'h2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t4_rst", {25'd0, s1, snap1, v1, busy1}, 32'h0);
    scan1(4'b0011);
    chk("t4_valid", 32'(v1),    32'h1);
    chk("t4_snap",  32'(snap1), 32'h3);
    accept1();

`ifdef MUX41_SCAN_CHANGE_DETECT_EN
    scan1(4'b1010);
    chk("t5_snap_a",  32'(snap1), 32'hA);
    chk("t5_changed_a", 32'(ch1), 32'h1);
    accept1();
    scan1(4'b1010);
    chk("t5_changed_b", 32'(ch1), 32'h0);
    accept1();
    scan1(4'b1011);
    chk("t5_snap_c",  32'(snap1), 32'hB);
    chk("t5_changed_c", 32'(ch1), 32'h1);
    accept1();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mux41_scan_ctrl.md
Name: mux41_scan_ctrl

Overview:
- Upstream/downstream controller for the 4:1 mux (`mux41`).
- Drives the mux select `s`, steps through every channel, samples mux output `y` on each, and assembles a parallel snapshot of all channel values.
- Presents the snapshot on a valid/ready handshake to the consumer.
- Together with the mux it forms a parallel-to-serial-to-parallel channel scanner.

Parameters:
- NCH, 4: number of mux channels scanned; must equal the mux input count.
- SELW, 2: select width; must satisfy 2**SELW >= NCH.
- DWELL, 1: cycles `s` is held per channel before `y` is sampled (settle time); legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk.
- start  in  1  request one scan; accepted only in IDLE.
- s  out  SELW  mux select, wired to mux `s`.
- y  in  1  mux output, wired from mux `y`.
- snap  out  NCH  captured snapshot; bit k = y observed with s==k.
- snap_valid  out  1  snapshot available.
- snap_ready  in  1  consumer accepts snapshot.
- busy  out  1  high in SCAN or VALID.

Behaviour:
- Reset (rst_n low at posedge): state=IDLE, s=0, snap=0, snap_valid=0, busy=0, dwell counter=0, shadow register=0.
- Reset has priority over every other input, including mid-scan and mid-handshake.
- States are IDLE, SCAN and VALID. Registered outputs, Moore style.
- IDLE:
  - s=0, busy=0, snap_valid=0.
  - start=1 at edge → SCAN, s=0, cnt=0.
- SCAN:
  - busy=1. cnt increments each edge.
  - At an edge where cnt==DWELL-1: shadow[s] <= y, cnt <= 0.
  - If s==NCH-1 at that edge: snap <= shadow with bit NCH-1 replaced by y, snap_valid <= 1, state → VALID, s <= 0.
  - Otherwise s <= s+1.
  - start is ignored in SCAN.
- Latency: snap_valid is visible after edge E+NCH*DWELL, where E is the start-accepting edge. Example: NCH=4, DWELL=1 → 4 edges.
- VALID:
  - snap and snap_valid hold stable until snap_ready=1 at an edge.
  - On acceptance: snap_valid <= 0, state → IDLE. snap keeps its last value.
  - start in the same cycle as acceptance is ignored; a new scan needs start in IDLE.
- snap_ready outside VALID has no effect.
- s never exceeds NCH-1. Unused select codes (NCH < 2**SELW) are never driven.
- y is sampled only on dwell-final edges. Changes on y at other times have no effect.

Optional Feature:
- Macro: MUX41_SCAN_CHANGE_DETECT_EN.
- With the macro defined:
  - Extra output port `changed` (1 bit) and an internal prev_snap register (reset 0).
  - On the edge that loads snap: changed <= (new snap != prev_snap), prev_snap <= new snap.
  - changed is valid while snap_valid=1 and resets to 0.
- Without the macro: no `changed` port, no prev_snap register. Behaviour is otherwise identical.

Decomposition:
- Package mux41_scan_pkg holds:
  - state enum {IDLE, SCAN, VALID};
  - default constants NCH=4, SELW=2, DWELL_MAX=15;
  - counter width localparam.
- One sub-module: scan_dwell_cnt.
  - Clear, enable and terminal-count output at DWELL-1.
  - Same clk/rst_n convention.
- FSM and snapshot registers stay in the top module.

Test Plan:
- Bench setup for all scenarios: NCH=4, DWELL=1 unless stated. A behavioural mux model drives y = i[s].
- i=4'b0101, start pulse → s sequence 0,1,2,3; snap=4'b0101 and snap_valid=1 after 4 edges; snap_ready=1 → snap_valid=0, state IDLE next edge.
- i=4'b1000, snap_ready held 0 for 10 cycles → snap=4'b1000 with snap_valid held stable throughout; start pulses in this window ignored; accepted on the first edge with snap_ready=1.
- DWELL=2, i=4'b0110; i changes to 4'b1111 during the first (non-sampling) dwell cycle of channel 2, before that channel is sampled → each s value held 2 cycles; snap=4'b1110, valid after 8 edges.
- rst_n=0 while s==2 in SCAN → next edge: s=0, snap=0, snap_valid=0, busy=0; the subsequent scan with i=4'b0011 yields 4'b0011.
- MUX41_SCAN_CHANGE_DETECT_EN defined; two scans with i=4'b1010, then a third with i=4'b1011 → changed=1, 0, 1 respectively.
